// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of one shared single-port RAM.
// Latency: grant one cycle after the request is sampled; read data one cycle after the grant.
// Backpressure: requesters hold their command until their grant pulse; the loser of a tie waits one cycle.
module ram_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req1,
  input  logic          req2,
  input  logic          we1,
  input  logic          we2,
  input  logic [AW-1:0] a1,
  input  logic [AW-1:0] a2,
  input  logic [DW-1:0] wd1,
  input  logic [DW-1:0] wd2,
  output logic          gnt1,
  output logic          gnt2,
  output logic          rvalid1,
  output logic          rvalid2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // State names the owner of the RAM command slot in the current cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2
  } state_t;

  state_t state;
  logic   last;   // 1: port 2 was granted most recently, so port 1 wins the next tie
  logic   elig1;
  logic   elig2;
  logic   pick1;
  logic   pick2;

  // A port granted this cycle is still holding its old command, so it sits out the next decision.
  always_comb begin
    elig1 = req1 & ~gnt1;
    elig2 = req2 & ~gnt2;
    pick1 = elig1 & (~elig2 | last);
    pick2 = elig2 & ~pick1;
  end

  // Arbitration FSM: registers the winner's command onto the RAM port and tracks read returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt1      <= 1'b0;
      gnt2      <= 1'b0;
      rvalid1   <= 1'b0;
      rvalid2   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      last      <= 1'b1;
    end else begin
      // The RAM samples the current slot's read at this edge; its data appears next cycle.
      rvalid1 <= (state == P1) & ~mem_we;
      rvalid2 <= (state == P2) & ~mem_we;
      gnt1    <= pick1;
      gnt2    <= pick2;
      if (pick1) begin
        state     <= P1;
        mem_we    <= we1;
        mem_addr  <= a1;
        mem_wdata <= wd1;
        last      <= 1'b0;
      end else if (pick2) begin
        state     <= P2;
        mem_we    <= we2;
        mem_addr  <= a2;
        mem_wdata <= wd2;
        last      <= 1'b1;
      end else begin
        // Address and write data hold their last values while idle.
        state  <= IDLE;
        mem_we <= 1'b0;
      end
    end
  end

  // Both ports see the RAM output permanently; rvalid alone marks whose data it is.
  assign rd1 = mem_rdata;
  assign rd2 = mem_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, reference memory and per-port read scoreboards.
// Expected read data is queued at grant time from the reference memory, compared on rvalid.
// Requesters follow the hold-until-grant protocol, driven by a shared automatic task.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req1 = 1'b0, req2 = 1'b0, we1 = 1'b0, we2 = 1'b0;
  logic [7:0] a1 = '0, a2 = '0, wd1 = '0, wd2 = '0;
  logic       gnt1, gnt2, rvalid1, rvalid2, mem_we;
  logic [7:0] rd1, rd2, mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;

  logic [7:0] ram   [256];
  logic [7:0] model [256];

  typedef struct packed {
    logic [7:0]  d;
    logic [31:0] c;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int w1      = 0;
  int w2      = 0;

  ram_port_arbiter #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req1(req1), .req2(req2), .we1(we1), .we2(we2),
    .a1(a1), .a2(a2), .wd1(wd1), .wd2(wd2),
    .gnt1(gnt1), .gnt2(gnt2), .rvalid1(rvalid1), .rvalid2(rvalid2),
    .rd1(rd1), .rd2(rd2),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port RAM: write on mem_we, read data one cycle after the address.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: command port contents at grant, read returns, one-hot grants, fairness.
  always @(negedge clk) begin
    if (!rst_n) begin
      w1 = 0;
      w2 = 0;
    end else begin
      if (rvalid1) begin
        if (q1.size() == 0) chk("rv1_spurious", rvalid1, 1'b0);
        else begin
          e1 = q1.pop_front();
          chk("rd1", rd1, e1.d);
          chk("rv1_cycle", cyc, e1.c + 1);
        end
      end else if (q1.size() > 0 && cyc > int'(q1[0].c) + 1) begin
        chk("rv1_missing", rvalid1, 1'b1);
        void'(q1.pop_front());
      end
      if (rvalid2) begin
        if (q2.size() == 0) chk("rv2_spurious", rvalid2, 1'b0);
        else begin
          e2 = q2.pop_front();
          chk("rd2", rd2, e2.d);
          chk("rv2_cycle", cyc, e2.c + 1);
        end
      end else if (q2.size() > 0 && cyc > int'(q2[0].c) + 1) begin
        chk("rv2_missing", rvalid2, 1'b1);
        void'(q2.pop_front());
      end

      if (gnt1 || gnt2) chk("gnt_onehot", gnt1 & gnt2, 1'b0);
      else              chk("idle_we", mem_we, 1'b0);

      if (gnt1) begin
        chk("fair1", w1 <= 2, 1'b1);
        w1 = 0;
        chk("mem_we1", mem_we, we1);
        chk("mem_addr1", mem_addr, a1);
        if (we1) begin
          chk("mem_wdata1", mem_wdata, wd1);
          model[a1] = wd1;
        end else q1.push_back('{d: model[a1], c: cyc});
      end else if (req1) w1++;
      else w1 = 0;

      if (gnt2) begin
        chk("fair2", w2 <= 2, 1'b1);
        w2 = 0;
        chk("mem_we2", mem_we, we2);
        chk("mem_addr2", mem_addr, a2);
        if (we2) begin
          chk("mem_wdata2", mem_wdata, wd2);
          model[a2] = wd2;
        end else q2.push_back('{d: model[a2], c: cyc});
      end else if (req2) w2++;
      else w2 = 0;
    end
  end

  // Present a command on port p, hold it until the grant is seen, return the grant cycle.
  task automatic issue(input int p, input logic we, input logic [7:0] a, input logic [7:0] d,
                       output int gc);
    gc = -1;
    if (p == 1) begin req1 = 1'b1; we1 = we; a1 = a; wd1 = d; end
    else        begin req2 = 1'b1; we2 = we; a2 = a; wd2 = d; end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((p == 1) ? gnt1 : gnt2) begin
        gc = cyc;
        break;
      end
    end
    if (gc < 0) chk("grant_timeout", (p == 1) ? gnt1 : gnt2, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic drop(input int p);
    if (p == 1) req1 = 1'b0;
    else        req2 = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt1"}, gnt1, 1'b0);
    chk({tag, "_gnt2"}, gnt2, 1'b0);
    chk({tag, "_rvalid1"}, rvalid1, 1'b0);
    chk({tag, "_rvalid2"}, rvalid2, 1'b0);
    chk({tag, "_mem_we"}, mem_we, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 8'h00);
    chk({tag, "_mem_wdata"}, mem_wdata, 8'h00);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int t0, g, g1, g2, f1, f2, l1, l2;

  initial begin
    // Power-on reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    release_reset();

    // Single write then read on port 1
    t0 = cyc;
    issue(1, 1'b1, 8'h10, 8'hA5, g);
    chk("wr_latency", g - t0, 1);
    t0 = cyc;
    issue(1, 1'b0, 8'h10, 8'h00, g);
    chk("rd_latency", g - t0, 1);
    drop(1);
    repeat (3) @(posedge clk);
    #1;

    // Tie right after reset: port 1 first, port 2 the next cycle
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    t0 = cyc;
    fork
      begin issue(1, 1'b1, 8'h00, 8'h11, g1); drop(1); end
      begin issue(2, 1'b1, 8'h01, 8'h22, g2); drop(2); end
    join
    chk("tie_gnt1_first", g1 - t0, 1);
    chk("tie_gnt2_next", g2 - g1, 1);
    issue(1, 1'b1, 8'h02, 8'h33, g);
    issue(1, 1'b1, 8'h03, 8'h44, g);
    drop(1);
    @(posedge clk);
    #1;

    // Continuous contention: 10 commands each, strict alternation
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          issue(1, 1'b1, 8'h40 + 8'(i), 8'h80 + 8'(i), g1);
          if (i == 0) f1 = g1;
          else chk("alt_port1_spacing", g1 - l1, 2);
          l1 = g1;
        end
        drop(1);
      end
      begin
        for (int i = 0; i < 10; i++) begin
          issue(2, 1'b0, 8'(i % 4), 8'h00, g2);
          if (i == 0) f2 = g2;
          else chk("alt_port2_spacing", g2 - l2, 2);
          l2 = g2;
        end
        drop(2);
      end
    join
    chk("alt_first_offset", (f1 > f2) ? f1 - f2 : f2 - f1, 1);
    chk("alt_20_in_20", ((l1 > l2) ? l1 : l2) - ((f1 < f2) ? f1 : f2), 19);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back reads on port 2 alone
    for (int i = 0; i < 4; i++) begin
      issue(2, 1'b0, 8'(i), 8'h00, g2);
      if (i > 0) chk("b2b_port2_spacing", g2 - l2, 2);
      l2 = g2;
    end
    drop(2);
    repeat (3) @(posedge clk);
    #1;

    // Read-after-write across ports (port 1 wins the tie: port 2 was last)
    fork
      begin issue(1, 1'b1, 8'h20, 8'h3C, g1); drop(1); end
      begin issue(2, 1'b0, 8'h20, 8'h00, g2); drop(2); end
    join
    chk("raw_order", g2 - g1, 1);
    chk("raw_model", model[8'h20], 8'h3C);
    repeat (3) @(posedge clk);
    #1;

    // Reset asserted mid-cycle while a read return is in flight and a new command is pending
    issue(1, 1'b0, 8'h10, 8'h00, g);
    chk("pre_reset_rvalid1", rvalid1, 1'b1);
    req1 = 1'b1; we1 = 1'b1; a1 = 8'h55; wd1 = 8'h99;
    #2;
    rst_n = 1'b0;
    q1.delete();
    q2.delete();
    #1;
    check_reset_outputs("midreset");
    req1 = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    chk("post_release_idle", gnt1, 1'b0);
    t0 = cyc;
    issue(1, 1'b0, 8'h10, 8'h00, g);
    chk("post_reset_latency", g - t0, 1);
    drop(1);
    repeat (4) @(posedge clk);
    #1;
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, meaning address width (memory depth 2**AW words).
REQ-002 SHALL have parameter DW, default 8, meaning data word width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports req1/req2  input  1  requester command valid.
REQ-006 SHALL have ports we1/we2  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports a1/a2  input  AW  requester address.
REQ-008 SHALL have ports wd1/wd2  input  DW  requester write data.
REQ-009 SHALL have ports gnt1/gnt2  output  1  registered one-cycle grant pulse.
REQ-010 SHALL have ports rvalid1/rvalid2  output  1  registered one-cycle read-data-valid pulse.
REQ-011 SHALL have ports rd1/rd2  output  DW  read data, driven from mem_rdata.
REQ-012 SHALL have ports mem_we, mem_addr, mem_wdata  output  1/AW/DW  registered command to the single shared RAM port.
REQ-013 SHALL have port mem_rdata  input  DW  RAM read data, valid the cycle after the RAM samples mem_addr.

Function
REQ-014 SHALL implement FSM states IDLE, P1, P2; state = owner of the command slot in the current cycle.
REQ-015 SHALL compute eligibility per edge: elig_i = req_i AND NOT gnt_i (a requester granted this cycle is masked for the next decision).
REQ-016 SHALL, when no requester is eligible, go to IDLE: gnt1=gnt2=0, mem_we=0, mem_addr/mem_wdata hold last values.
REQ-017 SHALL, when exactly one requester is eligible, go to P1 or P2 for it.
REQ-018 SHALL, when both are eligible, grant the requester not granted most recently (round-robin via 1-bit last register).
REQ-019 SHALL, on entering Pi, register gnt_i=1, mem_we=we_i, mem_addr=a_i, mem_wdata=wd_i in the same edge; update last=i.
REQ-020 SHALL assert at most one of gnt1/gnt2 in any cycle; mem_we SHALL be 1 only in a P1/P2 cycle with a write command.
REQ-021 SHALL, for a read granted in cycle N (state Pi), pulse rvalid_i in cycle N+1 only; rd_i = mem_rdata in that cycle.
REQ-022 SHALL never pulse rvalid for writes.
REQ-023 SHALL drive rd1 and rd2 from mem_rdata at all times; only rvalid qualifies them.
REQ-024 Latency: req_i high before edge E, sole eligible requester -> gnt_i in cycle after E; read data in the cycle after that.
REQ-025 Requester protocol: hold req_i, we_i, a_i, wd_i stable until gnt_i seen; drop or change them in the cycle after gnt_i; re-asserting then is a new command.
REQ-026 Throughput: one command per cycle when both requesters are continuously active (alternating P1, P2); at most one command per two cycles per requester.
REQ-027 Fairness: a waiting eligible requester SHALL be granted within 2 cycles of becoming eligible.
REQ-028 Ordering: commands issue in grant order; read in cycle N+1 to an address written in cycle N returns the new data.

Reset
REQ-029 SHALL, while rst_n=0, force state=IDLE, gnt1=gnt2=0, rvalid1=rvalid2=0, mem_we=0, mem_addr=0, mem_wdata=0, last=2 (port 1 wins first tie).
REQ-030 SHALL, on reset assert mid-transaction, drop pending grants and rvalid pulses immediately; no command is replayed after reset.
REQ-031 SHALL accept no command in the first edge after rst_n deasserts unless req is sampled high at that edge; normal arbitration from that edge.

Verification
REQ-032 Reset: rst_n=0 asynchronously mid-cycle with req1=1 -> all outputs 0 immediately; after release, req1=1 -> gnt1 next cycle.
REQ-033 Single write/read: port1 write a=0x10 wd=0xA5, then read a=0x10 -> mem_we=1 in gnt cycle; rvalid1 one cycle after read grant, rd1=0xA5.
REQ-034 Tie after reset: req1=req2=1 same edge -> gnt1 first, gnt2 next cycle, never both in one cycle.
REQ-035 Continuous contention: both held active for 10 commands each -> strict alternation P1,P2,...; 20 commands in 20 cycles; no requester waits over 2 cycles.
REQ-036 Back-to-back single requester: req2 reads 0x00..0x03 -> gnt2 every other cycle, 4 rvalid2 pulses with matching data, rvalid1 stays 0.
REQ-037 RAW hazard: port1 write 0x20<=0x3C granted cycle N, port2 read 0x20 granted N+1 -> rvalid2 in N+2 with rd2=0x3C.
